// File: rtl/hazard_scoreboard.sv
// Decode hazard unit: per-port EX/MEM bypass, 32-entry load scoreboard, stall; LL/SC tracker under HAZARD_LLSC_EN.
// Forwarding and stall are combinational (zero latency); stall holds IF/ID while scoreboard counters keep draining.
module hazard_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_flush,
  input  logic [5*NUM_RD-1:0]      rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  input  logic [DATA_W*NUM_RD-1:0] rf_data,
  input  logic                     id_we,
  input  logic [4:0]               id_wr_addr,
  input  logic                     id_load,
  input  logic                     id_store,
  input  logic                     id_ll,
  input  logic                     id_sc,
  input  logic                     ex_we,
  input  logic [4:0]               ex_wr_addr,
  input  logic [DATA_W-1:0]        ex_result,
  input  logic                     mem_we,
  input  logic [4:0]               mem_wr_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [DATA_W*NUM_RD-1:0] fwd_data,
  output logic                     stall,
  output logic                     sc_mask,
  output logic                     atomic
);

  localparam int CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             issue;
  logic             ld_set;

  assign issue  = id_valid & ~id_flush & ~stall;
  assign ld_set = issue & id_load & id_we & (id_wr_addr != 5'd0);

  // A fresh load overrides the decrement of the same entry.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (ld_set && (id_wr_addr == 5'(r))) begin
        cnt_d[r] = CNT_LOAD;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_used[p] && (rd_addr[5*p +: 5] != 5'd0) && (cnt_q[rd_addr[5*p +: 5]] != '0)) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_addr[5*p +: 5] == 5'd0) begin
        fwd_data[DATA_W*p +: DATA_W] = '0;
      end else if (ex_we && (ex_wr_addr == rd_addr[5*p +: 5])) begin
        fwd_data[DATA_W*p +: DATA_W] = ex_result;
      end else if (mem_we && (mem_wr_addr == rd_addr[5*p +: 5])) begin
        fwd_data[DATA_W*p +: DATA_W] = mem_data;
      end else begin
        fwd_data[DATA_W*p +: DATA_W] = rf_data[DATA_W*p +: DATA_W];
      end
    end
  end

`ifdef HAZARD_LLSC_EN
  logic atomic_q;
  logic atomic_d;

  always_comb begin
    atomic_d = atomic_q;
    if (issue && id_ll) begin
      atomic_d = 1'b1;
    end else if (issue && (id_store || id_sc)) begin
      atomic_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      atomic_q <= 1'b0;
    end else begin
      atomic_q <= atomic_d;
    end
  end

  assign atomic  = atomic_q;
  assign sc_mask = id_valid & id_sc & ~atomic_q;
`else
  logic unused_llsc;
  assign unused_llsc = id_ll ^ id_sc ^ id_store;
  assign atomic      = 1'b0;
  assign sc_mask     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus; directed table plus random vs. model.
module tb_hazard_scoreboard;

`ifdef HAZARD_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  typedef struct {
    logic        rst, vld, flush;
    logic [4:0]  ra0, ra1;
    logic [1:0]  used;
    logic        we;
    logic [4:0]  wa;
    logic        load, store, ll, sc;
    logic        ex_we;
    logic [4:0]  ex_wa;
    logic [31:0] ex_res;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [31:0] mem_dat;
    logic        e_st1, e_st3;
    logic [31:0] e_f0, e_f1;
    logic        e_scm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_flush, id_we, id_load, id_store, id_ll, id_sc;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used;
  logic [63:0] rf_data;
  logic [4:0]  id_wr_addr, ex_wr_addr, mem_wr_addr;
  logic        ex_we, mem_we;
  logic [31:0] ex_result, mem_data;
  logic [63:0] fwd1, fwd3;
  logic        stall1, stall3, scm1, scm3, at1, at3;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int ldc1 [32];
  int ldc3 [32];
  bit res1, res3;

  always #5 clk = ~clk;

  assign rf_data = {32'hB000_0000 | {27'd0, rd_addr[9:5]}, 32'hA000_0000 | {27'd0, rd_addr[4:0]}};

  hazard_scoreboard #(.DATA_W(32), .NUM_RD(2), .LOAD_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush), .rd_addr(rd_addr),
    .rd_used(rd_used), .rf_data(rf_data), .id_we(id_we), .id_wr_addr(id_wr_addr),
    .id_load(id_load), .id_store(id_store), .id_ll(id_ll), .id_sc(id_sc),
    .ex_we(ex_we), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_data(mem_data),
    .fwd_data(fwd1), .stall(stall1), .sc_mask(scm1), .atomic(at1));

  hazard_scoreboard #(.DATA_W(32), .NUM_RD(2), .LOAD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush), .rd_addr(rd_addr),
    .rd_used(rd_used), .rf_data(rf_data), .id_we(id_we), .id_wr_addr(id_wr_addr),
    .id_load(id_load), .id_store(id_store), .id_ll(id_ll), .id_sc(id_sc),
    .ex_we(ex_we), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_data(mem_data),
    .fwd_data(fwd3), .stall(stall3), .sc_mask(scm3), .atomic(at3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst_v, vld, fl, input logic [4:0] ra0, ra1,
                              input logic [1:0] used, input logic we, input logic [4:0] wa,
                              input logic ld, exwe, input logic [4:0] exwa, input logic [31:0] exres,
                              input logic mwe, input logic [4:0] mwa, input logic [31:0] mdat,
                              input logic es1, es3, input logic [31:0] ef0, ef1);
    vec_t v;
    v.rst = rst_v; v.vld = vld; v.flush = fl; v.ra0 = ra0; v.ra1 = ra1; v.used = used;
    v.we = we; v.wa = wa; v.load = ld; v.store = 1'b0; v.ll = 1'b0; v.sc = 1'b0;
    v.ex_we = exwe; v.ex_wa = exwa; v.ex_res = exres;
    v.mem_we = mwe; v.mem_wa = mwa; v.mem_dat = mdat;
    v.e_st1 = es1; v.e_st3 = es3; v.e_f0 = ef0; v.e_f1 = ef1; v.e_scm = 1'b0;
    return v;
  endfunction

  // A register is busy for the LAT cycles following the cycle its load issued.
  function automatic bit busy(input int ld_cycle, input int lat);
    return ((cyc - ld_cycle) >= 1) && ((cyc - ld_cycle) <= lat);
  endfunction

  function automatic bit model_stall(input vec_t v, input int lat, input bit which3);
    int c0, c1;
    c0 = which3 ? ldc3[v.ra0] : ldc1[v.ra0];
    c1 = which3 ? ldc3[v.ra1] : ldc1[v.ra1];
    return (v.used[0] && v.ra0 != 0 && busy(c0, lat)) || (v.used[1] && v.ra1 != 0 && busy(c1, lat));
  endfunction

  function automatic logic [31:0] model_fwd(input vec_t v, input logic [4:0] ra, input logic [31:0] rf);
    if (ra == 5'd0) return 32'd0;
    if (v.ex_we && v.ex_wa == ra) return v.ex_res;
    if (v.mem_we && v.mem_wa == ra) return v.mem_dat;
    return rf;
  endfunction

  task automatic apply(input vec_t v, input bit hand);
    bit e1, e3, i1, i3;
    logic [31:0] f0, f1;
    @(negedge clk);
    rst = v.rst; id_valid = v.vld; id_flush = v.flush; rd_addr = {v.ra1, v.ra0}; rd_used = v.used;
    id_we = v.we; id_wr_addr = v.wa; id_load = v.load; id_store = v.store; id_ll = v.ll; id_sc = v.sc;
    ex_we = v.ex_we; ex_wr_addr = v.ex_wa; ex_result = v.ex_res;
    mem_we = v.mem_we; mem_wr_addr = v.mem_wa; mem_data = v.mem_dat;
    #1;
    e1 = model_stall(v, 1, 1'b0);
    e3 = model_stall(v, 3, 1'b1);
    f0 = model_fwd(v, v.ra0, 32'hA000_0000 | 32'(v.ra0));
    f1 = model_fwd(v, v.ra1, 32'hB000_0000 | 32'(v.ra1));
    chk("stall_lat1", 32'(stall1), 32'(e1));
    chk("stall_lat3", 32'(stall3), 32'(e3));
    chk("fwd0_lat1", fwd1[31:0], f0);
    chk("fwd1_lat1", fwd1[63:32], f1);
    chk("fwd0_lat3", fwd3[31:0], f0);
    chk("fwd1_lat3", fwd3[63:32], f1);
    chk("atomic_lat1", 32'(at1), LLSC ? 32'(res1) : 32'd0);
    chk("atomic_lat3", 32'(at3), LLSC ? 32'(res3) : 32'd0);
    chk("sc_mask_lat1", 32'(scm1), LLSC ? 32'(v.vld & v.sc & ~res1) : 32'd0);
    chk("sc_mask_lat3", 32'(scm3), LLSC ? 32'(v.vld & v.sc & ~res3) : 32'd0);
    if (hand) begin
      chk("tbl_stall_lat1", 32'(stall1), 32'(v.e_st1));
      chk("tbl_stall_lat3", 32'(stall3), 32'(v.e_st3));
      chk("tbl_fwd0", fwd1[31:0], v.e_f0);
      chk("tbl_fwd1", fwd1[63:32], v.e_f1);
      chk("tbl_sc_mask", 32'(scm1), 32'(v.e_scm));
    end
    i1 = v.vld & ~v.flush & ~e1;
    i3 = v.vld & ~v.flush & ~e3;
    @(posedge clk);
    if (v.rst) begin
      for (int r = 0; r < 32; r++) begin
        ldc1[r] = -1000;
        ldc3[r] = -1000;
      end
      res1 = 1'b0;
      res3 = 1'b0;
    end else begin
      if (i1 && v.load && v.we && v.wa != 0) ldc1[v.wa] = cyc;
      if (i3 && v.load && v.we && v.wa != 0) ldc3[v.wa] = cyc;
      if (i1 && v.ll) res1 = 1'b1; else if (i1 && (v.store || v.sc)) res1 = 1'b0;
      if (i3 && v.ll) res3 = 1'b1; else if (i3 && (v.store || v.sc)) res3 = 1'b0;
    end
    cyc++;
  endtask

  vec_t tbl [21];
  vec_t v;

  initial begin
    for (int r = 0; r < 32; r++) begin
      ldc1[r] = -1000;
      ldc3[r] = -1000;
    end
    res1 = 1'b0; res3 = 1'b0;
    rst = 1'b1; id_valid = 1'b0; id_flush = 1'b0; rd_addr = '0; rd_used = '0;
    id_we = 1'b0; id_wr_addr = '0; id_load = 1'b0; id_store = 1'b0; id_ll = 1'b0; id_sc = 1'b0;
    ex_we = 1'b0; ex_wr_addr = '0; ex_result = '0; mem_we = 1'b0; mem_wr_addr = '0; mem_data = '0;
    repeat (2) @(posedge clk);

    //            rst vld fl ra0 ra1 used  we wa ld exwe exwa exres  mwe mwa mdat           s1 s3 f0             f1
    tbl[0]  = mk(0, 0, 0, 3,  0,  2'b11, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_0003, 32'h0);
    tbl[1]  = mk(0, 1, 0, 1,  2,  2'b00, 1, 5,  1, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_0001, 32'hB000_0002);
    tbl[2]  = mk(0, 1, 0, 5,  5,  2'b11, 1, 6,  0, 0, 0, 32'h0,  0, 0, 32'h0,          1, 1, 32'hA000_0005, 32'hB000_0005);
    tbl[3]  = mk(0, 1, 0, 5,  5,  2'b11, 1, 6,  0, 0, 0, 32'h0,  1, 5, 32'hDEAD_BEEF,  0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tbl[4]  = mk(0, 1, 0, 5,  5,  2'b11, 1, 6,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 1, 32'hA000_0005, 32'hB000_0005);
    tbl[5]  = mk(0, 1, 0, 5,  5,  2'b11, 1, 6,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_0005, 32'hB000_0005);
    tbl[6]  = mk(0, 1, 0, 0,  0,  2'b00, 1, 7,  1, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'h0,         32'h0);
    tbl[7]  = mk(0, 1, 0, 8,  7,  2'b01, 1, 12, 0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_0008, 32'hB000_0007);
    tbl[8]  = mk(0, 1, 0, 7,  0,  2'b01, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 1, 32'hA000_0007, 32'h0);
    tbl[9]  = mk(0, 0, 0, 7,  0,  2'b01, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 1, 32'hA000_0007, 32'h0);
    tbl[10] = mk(0, 0, 0, 7,  0,  2'b01, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_0007, 32'h0);
    tbl[11] = mk(0, 0, 0, 4,  4,  2'b00, 0, 0,  0, 1, 4, 32'h11, 1, 4, 32'h22,         0, 0, 32'h11,        32'h11);
    tbl[12] = mk(0, 0, 0, 0,  4,  2'b00, 0, 0,  0, 1, 0, 32'h33, 1, 4, 32'h22,         0, 0, 32'h0,         32'h22);
    tbl[13] = mk(0, 0, 0, 4,  3,  2'b00, 0, 0,  0, 0, 4, 32'h11, 1, 4, 32'h22,         0, 0, 32'h22,        32'hB000_0003);
    tbl[14] = mk(0, 1, 0, 0,  0,  2'b00, 1, 10, 1, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'h0,         32'h0);
    tbl[15] = mk(0, 1, 1, 10, 0,  2'b01, 1, 11, 1, 0, 0, 32'h0,  0, 0, 32'h0,          1, 1, 32'hA000_000A, 32'h0);
    tbl[16] = mk(0, 0, 0, 11, 0,  2'b01, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_000B, 32'h0);
    tbl[17] = mk(0, 0, 0, 10, 0,  2'b01, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 1, 32'hA000_000A, 32'h0);
    tbl[18] = mk(0, 1, 0, 0,  0,  2'b00, 1, 9,  1, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'h0,         32'h0);
    tbl[19] = mk(1, 0, 0, 0,  0,  2'b00, 0, 0,  0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'h0,         32'h0);
    tbl[20] = mk(0, 1, 0, 9,  9,  2'b11, 1, 13, 0, 0, 0, 32'h0,  0, 0, 32'h0,          0, 0, 32'hA000_0009, 32'hB000_0009);

    for (int i = 0; i < 21; i++) apply(tbl[i], 1'b1);

    // LL/SC sequences: LL,SC -> keep; LL,SW,SC -> mask; reset (and a flushed LL) then SC -> mask.
    v = mk(0, 1, 0, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.ll = 1'b1; apply(v, 1'b1);
    v = mk(0, 1, 0, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.sc = 1'b1; apply(v, 1'b1);
    v = mk(0, 1, 0, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.ll = 1'b1; apply(v, 1'b1);
    v = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.store = 1'b1; apply(v, 1'b1);
    v = mk(0, 1, 0, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.sc = 1'b1; v.e_scm = LLSC; apply(v, 1'b1);
    v = mk(0, 1, 0, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.ll = 1'b1; apply(v, 1'b1);
    v = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); apply(v, 1'b1);
    v = mk(0, 1, 1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.ll = 1'b1; apply(v, 1'b1);
    v = mk(0, 1, 0, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.sc = 1'b1; v.e_scm = LLSC; apply(v, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      int kind;
      kind = int'($urandom_range(4));
      v = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst     = ($urandom_range(63) == 0);
      v.vld     = ($urandom_range(7) != 0);
      v.flush   = ($urandom_range(7) == 0);
      v.ra0     = ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      v.ra1     = ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      v.used    = 2'($urandom_range(3));
      v.wa      = 5'($urandom_range(7));
      v.we      = (kind != 2) && ($urandom_range(7) != 0);
      v.load    = (kind == 1) || (kind == 3);
      v.store   = (kind == 2);
      v.ll      = (kind == 3);
      v.sc      = (kind == 4);
      v.ex_we   = 1'($urandom_range(1));
      v.ex_wa   = 5'($urandom_range(7));
      v.ex_res  = $urandom;
      v.mem_we  = 1'($urandom_range(1));
      v.mem_wa  = 5'($urandom_range(7));
      v.mem_dat = $urandom;
      apply(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
